// File: rtl/enc_rr_arbiter.sv
// Eight-way fixed-priority / round-robin arbiter with registered one-hot grant and binary index.
// Optional forced release of long-held grants is enabled by defining ARB_TIMEOUT_EN.
module enc_rr_arbiter #(
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             sel,
  input  logic             done,
  output logic             grant_valid,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_pulse
);

  // state | meaning
  // IDLE  | no owner, outputs cleared, waiting for any request
  // GRANT | one requester owns the resource until done (or forced release)
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (N != (1 << IDX_W)) begin : g_n_chk
    $error("enc_rr_arbiter: N must equal 2**IDX_W");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_chk
    $error("enc_rr_arbiter: TIMEOUT must be within 2..255");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] fp_idx, rr_idx, win_idx;
  logic             req_any;
  logic             release_now;
  logic             force_rel;
  logic             load, clear;

  assign req_any = |req;

  // Reverse scans so the lowest offset seen last wins, without needing a break.
  always_comb begin
    fp_idx = '0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) fp_idx = IDX_W'(k);
      if (req[ptr + IDX_W'(k)]) rr_idx = ptr + IDX_W'(k);
    end
    win_idx = sel ? rr_idx : fp_idx;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] hold_cnt;

  assign force_rel = (state == GRANT) && !done && (hold_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= force_rel;
      if (load || clear) hold_cnt <= '0;
      else if (state == GRANT) hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign force_rel     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign release_now = done || force_rel;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (req_any) begin
            load = 1'b1;
          end else begin
            clear     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_oh    <= '0;
      grant_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        ptr         <= win_idx + IDX_W'(1);
        grant_valid <= 1'b1;
        grant_oh    <= N'(1) << win_idx;
        grant_idx   <= win_idx;
      end else if (clear) begin
        grant_valid <= 1'b0;
        grant_oh    <= '0;
        grant_idx   <= '0;
      end
    end
  end

endmodule
